// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - 8x8 grayscale image controller: IROM load, 2x2 window ops, IRAM write-back
module lcd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       IROM_rd,
  output logic [5:0] IROM_A,
  input  logic [7:0] IROM_Q,
  output logic       IRAM_valid,
  output logic [7:0] IRAM_D,
  output logic [5:0] IRAM_A,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] img [0:63];
  logic [3:0] cmd_reg;
  logic [2:0] op_x;
  logic [2:0] op_y;

  // Window addressing and arithmetic
  logic [2:0] wx;
  logic [2:0] wy;
  logic [5:0] a_tl;
  logic [5:0] a_tr;
  logic [5:0] a_bl;
  logic [5:0] a_br;
  logic [7:0] p_tl;
  logic [7:0] p_tr;
  logic [7:0] p_bl;
  logic [7:0] p_br;
  logic [7:0] max_top;
  logic [7:0] max_bot;
  logic [7:0] min_top;
  logic [7:0] min_bot;
  logic [7:0] win_max;
  logic [7:0] win_min;
  logic [9:0] win_sum;
  logic [7:0] win_avg;
  logic       unused_sum_lsbs;
  logic [7:0] n_tl;
  logic [7:0] n_tr;
  logic [7:0] n_bl;
  logic [7:0] n_br;
  logic       win_wr;

  assign wx   = op_x - 3'd1;
  assign wy   = op_y - 3'd1;
  assign a_tl = {wy, wx};
  assign a_tr = a_tl + 6'd1;
  assign a_bl = a_tl + 6'd8;
  assign a_br = a_tl + 6'd9;

  assign p_tl = img[a_tl];
  assign p_tr = img[a_tr];
  assign p_bl = img[a_bl];
  assign p_br = img[a_br];

  assign max_top = (p_tl > p_tr) ? p_tl : p_tr;
  assign max_bot = (p_bl > p_br) ? p_bl : p_br;
  assign win_max = (max_top > max_bot) ? max_top : max_bot;
  assign min_top = (p_tl < p_tr) ? p_tl : p_tr;
  assign min_bot = (p_bl < p_br) ? p_bl : p_br;
  assign win_min = (min_top < min_bot) ? min_top : min_bot;

  assign win_sum = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
  assign win_avg = win_sum[9:2];
  assign unused_sum_lsbs = ^win_sum[1:0];

  // New window contents for the latched command; every output uses pre-command pixels
  always_comb begin
    n_tl   = p_tl;
    n_tr   = p_tr;
    n_bl   = p_bl;
    n_br   = p_br;
    win_wr = 1'b0;
    case (cmd_reg)
      4'h5: begin n_tl = win_max; n_tr = win_max; n_bl = win_max; n_br = win_max; win_wr = 1'b1; end
      4'h6: begin n_tl = win_min; n_tr = win_min; n_bl = win_min; n_br = win_min; win_wr = 1'b1; end
      4'h7: begin n_tl = win_avg; n_tr = win_avg; n_bl = win_avg; n_br = win_avg; win_wr = 1'b1; end
      4'h8: begin n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; win_wr = 1'b1; end
      4'h9: begin n_tl = p_bl; n_tr = p_tl; n_br = p_tr; n_bl = p_br; win_wr = 1'b1; end
      4'hA: begin n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr; win_wr = 1'b1; end
      4'hB: begin n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; win_wr = 1'b1; end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    IRAM_valid = 1'b0;
    IRAM_D     = 8'd0;
    case (state)
      S_LOAD: begin
        if (IROM_rd && (IROM_A == 6'd63)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (cmd_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = (cmd_reg == 4'h0) ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        IRAM_valid = 1'b1;
        IRAM_D     = img[IRAM_A];
        if (IRAM_A == 6'd63) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Control registers: load/write address counters, latched command, operation point
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IROM_rd <= 1'b0;
      IROM_A  <= 6'd0;
      IRAM_A  <= 6'd0;
      cmd_reg <= 4'h0;
      op_x    <= 3'd4;
      op_y    <= 3'd4;
    end else begin
      case (state)
        S_LOAD: begin
          if (!IROM_rd)               IROM_rd <= 1'b1;
          else if (IROM_A == 6'd63)   IROM_rd <= 1'b0;
          else                        IROM_A  <= IROM_A + 6'd1;
        end
        S_IDLE: begin
          if (cmd_valid) cmd_reg <= cmd;
        end
        S_EXEC: begin
          IRAM_A <= 6'd0;
          case (cmd_reg)
            4'h1: if (op_y > 3'd1) op_y <= op_y - 3'd1;
            4'h2: if (op_y < 3'd7) op_y <= op_y + 3'd1;
            4'h3: if (op_x > 3'd1) op_x <= op_x - 3'd1;
            4'h4: if (op_x < 3'd7) op_x <= op_x + 3'd1;
            default: ;
          endcase
        end
        S_WRITE: begin
          if (IRAM_A != 6'd63) IRAM_A <= IRAM_A + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Image buffer: filled from IROM during load, window rewritten by pixel commands
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && IROM_rd) begin
      img[IROM_A] <= IROM_Q;
    end else if ((state == S_EXEC) && win_wr) begin
      img[a_tl] <= n_tl;
      img[a_tr] <= n_tr;
      img[a_bl] <= n_bl;
      img[a_br] <= n_br;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  logic [7:0] irom [0:63];
  logic [7:0] iram [0:63];
  logic [7:0] expv [0:63];
  logic [7:0] gbuf [0:63];
  int         gx;
  int         gy;
  logic [3:0] stream [0:45];

  int checks = 0;
  int errors = 0;

  lcd_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .IROM_rd    (IROM_rd),
    .IROM_A     (IROM_A),
    .IROM_Q     (IROM_Q),
    .IRAM_valid (IRAM_valid),
    .IRAM_D     (IRAM_D),
    .IRAM_A     (IRAM_A),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // IROM and IRAM behavioural models, both active on the falling edge
  always @(negedge clk) begin
    if (IROM_rd) IROM_Q <= irom[IROM_A];
    if (IRAM_valid) iram[IRAM_A] <= IRAM_D;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp_val);
    checks++;
    assert (obs === exp_val) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_val);
    end
  endtask

  task automatic set_image();
    for (int k = 0; k < 64; k++) begin
      irom[k] = 8'(k * 3);
      iram[k] = 8'hff;
    end
  endtask

  task automatic snap_exp();
    for (int k = 0; k < 64; k++) expv[k] = irom[k];
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, int'(done), 1);
  endtask

  task automatic issue(input string tag, input logic [3:0] c);
    wait_idle(tag);
    cmd       = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_image(input string tag);
    for (int k = 0; k < 64; k++)
      chk($sformatf("%s_px%0d", tag, k), int'(iram[k]), int'(expv[k]));
  endtask

  task automatic run_win(input string tag, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                         input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec, input logic [7:0] ed);
    set_image();
    irom[27] = a; irom[28] = b; irom[35] = c; irom[36] = d;
    snap_exp();
    expv[27] = ea; expv[28] = eb; expv[35] = ec; expv[36] = ed;
    do_reset();
    issue(tag, op);
    issue(tag, 4'h0);
    wait_done(tag);
    check_image(tag);
  endtask

  task automatic apply_gold(input logic [3:0] c);
    int t;
    logic [7:0] a, b, e, d, m, s;
    logic [9:0] sum;
    t = (gy - 1) * 8 + (gx - 1);
    a = gbuf[t]; b = gbuf[t + 1]; e = gbuf[t + 8]; d = gbuf[t + 9];
    m = a; if (b > m) m = b; if (e > m) m = e; if (d > m) m = d;
    s = a; if (b < s) s = b; if (e < s) s = e; if (d < s) s = d;
    sum = 10'(a) + 10'(b) + 10'(e) + 10'(d);
    case (c)
      4'h1: if (gy > 1) gy--;
      4'h2: if (gy < 7) gy++;
      4'h3: if (gx > 1) gx--;
      4'h4: if (gx < 7) gx++;
      4'h5: begin gbuf[t] = m; gbuf[t + 1] = m; gbuf[t + 8] = m; gbuf[t + 9] = m; end
      4'h6: begin gbuf[t] = s; gbuf[t + 1] = s; gbuf[t + 8] = s; gbuf[t + 9] = s; end
      4'h7: begin
        gbuf[t] = sum[9:2]; gbuf[t + 1] = sum[9:2]; gbuf[t + 8] = sum[9:2]; gbuf[t + 9] = sum[9:2];
      end
      4'h8: begin gbuf[t] = b; gbuf[t + 1] = d; gbuf[t + 9] = e; gbuf[t + 8] = a; end
      4'h9: begin gbuf[t] = e; gbuf[t + 1] = a; gbuf[t + 9] = b; gbuf[t + 8] = d; end
      4'hA: begin gbuf[t] = e; gbuf[t + 8] = a; gbuf[t + 1] = d; gbuf[t + 9] = b; end
      4'hB: begin gbuf[t] = b; gbuf[t + 1] = a; gbuf[t + 8] = d; gbuf[t + 9] = e; end
      default: ;
    endcase
  endtask

  initial begin
    int bad;
    int done_edge;
    int busy_low;
    int idx;
    int prev_acc;
    int cyc;
    int bad_gap;

    // Reset values and load sequence, then immediate write-back
    set_image();
    snap_exp();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_irom_rd", int'(IROM_rd), 0);
    chk("rst_irom_a", int'(IROM_A), 0);
    chk("rst_iram_valid", int'(IRAM_valid), 0);
    chk("rst_iram_a", int'(IRAM_A), 0);
    chk("rst_iram_d", int'(IRAM_D), 0);
    @(negedge clk);
    reset = 1'b0;

    bad = 0;
    for (int e = 1; e <= 65; e++) begin
      @(posedge clk);
      #1;
      if (e <= 64) begin
        if (IROM_rd !== 1'b1 || IROM_A !== 6'(e - 1) || busy !== 1'b1 || IRAM_valid !== 1'b0) bad++;
      end else begin
        if (IROM_rd !== 1'b0 || busy !== 1'b0) bad++;
      end
    end
    chk("load_sequence", bad, 0);

    cmd       = 4'h0;
    cmd_valid = 1'b1;
    done_edge = 0;
    busy_low  = 0;
    for (int e = 66; e <= 200 && done_edge == 0; e++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) done_edge = e;
    end
    chk("done_latency", done_edge, 131);
    chk("busy_after_write", busy_low, 0);
    check_image("copy");

    bad = 0;
    cmd       = 4'h5;
    cmd_valid = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1 || done !== 1'b1 || IRAM_valid !== 1'b0) bad++;
    end
    cmd_valid = 1'b0;
    chk("done_terminal", bad, 0);

    // Window arithmetic at (4,4)
    run_win("max", 4'h5, 8'd10, 8'd20, 8'd30, 8'd41, 8'd41, 8'd41, 8'd41, 8'd41);
    run_win("min", 4'h6, 8'd10, 8'd20, 8'd30, 8'd41, 8'd10, 8'd10, 8'd10, 8'd10);
    run_win("avg", 4'h7, 8'd10, 8'd20, 8'd30, 8'd41, 8'd25, 8'd25, 8'd25, 8'd25);
    run_win("avg_wide", 4'h7, 8'd255, 8'd254, 8'd253, 8'd250, 8'd253, 8'd253, 8'd253, 8'd253);

    // Rotations and mirrors, arguments ordered TL,TR,BL,BR
    run_win("ccw", 4'h8, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd4, 8'd1, 8'd3);
    run_win("cw",  4'h9, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd1, 8'd4, 8'd2);
    run_win("mirx", 4'hA, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4, 8'd1, 8'd2);
    run_win("miry", 4'hB, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd1, 8'd4, 8'd3);
    run_win("nop", 4'hD, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4);

    // Clamp at (1,1): pixels 0,3,24,27 -> max 27
    set_image();
    snap_exp();
    expv[0] = 8'd27; expv[1] = 8'd27; expv[8] = 8'd27; expv[9] = 8'd27;
    do_reset();
    repeat (6) issue("clamp_lo", 4'h3);
    repeat (6) issue("clamp_lo", 4'h1);
    issue("clamp_lo", 4'h5);
    issue("clamp_lo", 4'h0);
    wait_done("clamp_lo");
    check_image("clamp_lo");

    // Clamp at (7,7): pixels 162,165,186,189 -> max 189
    set_image();
    snap_exp();
    expv[54] = 8'd189; expv[55] = 8'd189; expv[62] = 8'd189; expv[63] = 8'd189;
    do_reset();
    repeat (6) issue("clamp_hi", 4'h4);
    repeat (6) issue("clamp_hi", 4'h2);
    issue("clamp_hi", 4'h5);
    issue("clamp_hi", 4'h0);
    wait_done("clamp_hi");
    check_image("clamp_hi");

    // Back-to-back stream with cmd_valid held high, checked against a reference model
    for (int i = 0; i < 45; i++) stream[i] = 4'(((i * 7 + 3) % 15) + 1);
    stream[45] = 4'h0;
    set_image();
    for (int k = 0; k < 64; k++) begin
      irom[k] = 8'((k * 29 + 7) % 256);
      gbuf[k] = irom[k];
    end
    gx = 4;
    gy = 4;
    do_reset();
    cmd_valid = 1'b1;
    idx       = 0;
    prev_acc  = 0;
    bad_gap   = 0;
    cyc       = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      cmd = (idx < 46) ? stream[idx] : 4'h5;
      if (!busy && idx < 46) begin
        apply_gold(stream[idx]);
        if (idx > 0 && (cyc - prev_acc) != 2) bad_gap++;
        prev_acc = cyc;
        idx++;
      end
    end
    cmd_valid = 1'b0;
    chk("stream_done", int'(done), 1);
    chk("stream_accepts", idx, 46);
    chk("stream_busy_gap", bad_gap, 0);
    for (int k = 0; k < 64; k++) expv[k] = gbuf[k];
    check_image("stream");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
